// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS encoding constants.
// Holds the symbolic mnemonic enum used by the program loader and the
// opcode/funct field values that the single-cycle core's control decoder
// also consumes, so both sides stay in lock-step.
package mips_pkg;

   // Symbolic mnemonic codes as presented on in_mnem
   typedef enum logic [3:0] {
      MN_NOP     = 4'd0,
      MN_ADD     = 4'd1,
      MN_SUB     = 4'd2,
      MN_SLT     = 4'd3,
      MN_JR      = 4'd4,
      MN_ADDI    = 4'd5,
      MN_SLTI    = 4'd6,
      MN_ORI     = 4'd7,
      MN_LUI     = 4'd8,
      MN_LW      = 4'd9,
      MN_SW      = 4'd10,
      MN_BEQ     = 4'd11,
      MN_BNE     = 4'd12,
      MN_J       = 4'd13,
      MN_JAL     = 4'd14,
      MN_ILLEGAL = 4'd15
   } mnem_e;

   // Primary opcodes, instruction bits [31:26]
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type function codes, instruction bits [5:0]
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SLT   = 6'h2A;

endpackage

// File: rtl/mips_instr_pack.sv
// mips_instr_pack: combinational MIPS instruction packer.
// Maps a mnemonic plus register/immediate/target fields to a 32-bit
// machine word. Fields an encoding does not use are forced to zero.
// Ports:
//   mnem    in  mnemonic code
//   rs/rt/rd in 5-bit register fields
//   imm     in  16-bit immediate / branch offset
//   target  in  26-bit jump target
//   word    out encoded machine word
//   illegal out instruction must not be written
// Configuration: MIPS_ENC_CHECK_EN flags mnemonic 15 and lui with rs!=0
// as illegal; without it both are encoded (nop / rs masked) and illegal=0.
module mips_instr_pack
   import mips_pkg::*;
(
   input  mnem_e       mnem,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   output logic [31:0] word,
   output logic        illegal
);

   // Field packing per mnemonic; every unused field is explicitly zero
   always_comb begin
      word    = 32'h0000_0000;
      illegal = 1'b0;
      case (mnem)
         MN_NOP:  word = 32'h0000_0000;
         MN_ADD:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
         MN_SUB:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
         MN_SLT:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SLT};
         MN_JR:   word = {OP_RTYPE, rs, 5'd0, 5'd0, 5'd0, FN_JR};
         MN_ADDI: word = {OP_ADDI, rs, rt, imm};
         MN_SLTI: word = {OP_SLTI, rs, rt, imm};
         MN_ORI:  word = {OP_ORI, rs, rt, imm};
         MN_LUI: begin
            // lui has no source register; rs is dropped from the word
            word = {OP_LUI, 5'd0, rt, imm};
`ifdef MIPS_ENC_CHECK_EN
            illegal = (rs != 5'd0);
`else
            illegal = 1'b0;
`endif
         end
         MN_LW:   word = {OP_LW, rs, rt, imm};
         MN_SW:   word = {OP_SW, rs, rt, imm};
         MN_BEQ:  word = {OP_BEQ, rs, rt, imm};
         MN_BNE:  word = {OP_BNE, rs, rt, imm};
         MN_J:    word = {OP_J, target};
         MN_JAL:  word = {OP_JAL, target};
         MN_ILLEGAL: begin
            word = 32'h0000_0000;
`ifdef MIPS_ENC_CHECK_EN
            illegal = 1'b1;
`else
            illegal = 1'b0;
`endif
         end
         default: begin
            word    = 32'h0000_0000;
            illegal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: sequential program loader for the single-cycle core.
// Accepts one symbolic instruction per cycle (in_valid/in_ready), encodes it
// and writes it one cycle later to consecutive instruction-memory words
// starting at BASE_ADDR, stopping after DEPTH words.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   start, finish           begin/restart and end a load (start wins)
//   in_valid/in_ready       instruction handshake (in_ready is registered)
//   in_mnem, in_rs, in_rt, in_rd, in_imm, in_target  instruction fields
//   imem_we/addr/wdata      registered instruction-memory write port
//   count, full, done, err  load progress and status
// Configuration: MIPS_ENC_CHECK_EN enables illegal-instruction rejection
// (sticky err, no write, address held). Undefined: err stays 0.
module mips_instr_encoder
   import mips_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0,
   parameter int DEPTH     = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              finish,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_mnem,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_FULL = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

   state_e              state_r, state_nxt_s;
   logic                in_ready_r, done_r, full_r, err_r, imem_we_r;
   logic [ADDR_W-1:0]   addr_r, imem_addr_r;
   logic [31:0]         imem_wdata_r, word_s;
   logic [ADDR_W:0]     count_r, count_inc_s;
   logic                illegal_s, accept_s, write_s, last_s;

   mips_instr_pack u_pack (
      .mnem    (mnem_e'(in_mnem)),
      .rs      (in_rs),
      .rt      (in_rt),
      .rd      (in_rd),
      .imm     (in_imm),
      .target  (in_target),
      .word    (word_s),
      .illegal (illegal_s)
   );

   // Handshake qualification; a start cycle never writes (the load restarts)
   always_comb begin
      accept_s    = in_valid & in_ready_r;
      write_s     = accept_s & ~illegal_s & ~start;
      count_inc_s = count_r + {{ADDR_W{1'b0}}, 1'b1};
      last_s      = write_s & (count_inc_s == DEPTH_C);
   end

   // Next-state logic; start overrides everything including finish
   always_comb begin
      state_nxt_s = state_r;
      if (start) begin
         state_nxt_s = ST_LOAD;
      end else begin
         case (state_r)
            ST_IDLE: state_nxt_s = ST_IDLE;
            ST_LOAD: begin
               if (finish) begin
                  state_nxt_s = ST_DONE;
               end else if (last_s) begin
                  state_nxt_s = ST_FULL;
               end else begin
                  state_nxt_s = ST_LOAD;
               end
            end
            ST_FULL: begin
               if (finish) begin
                  state_nxt_s = ST_DONE;
               end else begin
                  state_nxt_s = ST_FULL;
               end
            end
            ST_DONE: state_nxt_s = ST_DONE;
            default: state_nxt_s = ST_IDLE;
         endcase
      end
   end

   // State register with state-derived in_ready/done registered alongside
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         in_ready_r <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         in_ready_r <= (state_nxt_s == ST_LOAD);
         done_r     <= (state_nxt_s == ST_DONE);
      end
   end

   // Address counter, progress flags and registered memory write port
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         imem_we_r    <= 1'b0;
         imem_addr_r  <= {ADDR_W{1'b0}};
         imem_wdata_r <= 32'h0000_0000;
         addr_r       <= {ADDR_W{1'b0}};
         count_r      <= {(ADDR_W + 1){1'b0}};
         full_r       <= 1'b0;
         err_r        <= 1'b0;
      end else if (start) begin
         imem_we_r <= 1'b0;
         addr_r    <= BASE_C;
         count_r   <= {(ADDR_W + 1){1'b0}};
         full_r    <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         imem_we_r <= write_s;
         if (write_s) begin
            imem_addr_r  <= addr_r;
            imem_wdata_r <= word_s;
            addr_r       <= addr_r + {{(ADDR_W - 1){1'b0}}, 1'b1};
            count_r      <= count_inc_s;
         end
         if (last_s) begin
            full_r <= 1'b1;
         end
         // illegal_s is constant 0 when checking is compiled out
         err_r <= err_r | (accept_s & illegal_s);
      end
   end

   assign in_ready   = in_ready_r;
   assign imem_we    = imem_we_r;
   assign imem_addr  = imem_addr_r;
   assign imem_wdata = imem_wdata_r;
   assign count      = count_r;
   assign full       = full_r;
   assign done       = done_r;
   assign err        = err_r;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder (ADDR_W=8, BASE_ADDR=0, DEPTH=4).
module tb_mips_instr_encoder;

   logic        clk = 1'b0;
   logic        reset, start, finish, in_valid, in_ready;
   logic [3:0]  in_mnem;
   logic [4:0]  in_rs, in_rt, in_rd;
   logic [15:0] in_imm;
   logic [25:0] in_target;
   logic        imem_we, full, done, err;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic [8:0]  count;

   int tests  = 0;
   int failed = 0;

   typedef struct {
      logic [3:0]  mnem;
      logic [4:0]  rs, rt, rd;
      logic [15:0] imm;
      logic [25:0] target;
      logic        exp_we;
      logic [31:0] exp_word;
      string       name;
   } vec_t;

   vec_t vecs[14];

   mips_instr_encoder #(.ADDR_W(8), .BASE_ADDR(0), .DEPTH(4)) dut (
      .clk(clk), .reset(reset), .start(start), .finish(finish),
      .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
      .in_target(in_target), .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .count(count), .full(full), .done(done),
      .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [3:0] m, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tg);
      in_valid  = 1'b1;
      in_mnem   = m;
      in_rs     = rs;
      in_rt     = rt;
      in_rd     = rd;
      in_imm    = imm;
      in_target = tg;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      // name, then fields; unused fields carry junk that must not leak
      vecs[0]  = '{4'd1,  5'd1,  5'd2,  5'd3,  16'hFFFF, 26'h3FFFFFF, 1'b1, 32'h0022_1820, "add"};
      vecs[1]  = '{4'd2,  5'd5,  5'd6,  5'd4,  16'hAAAA, 26'h2AAAAAA, 1'b1, 32'h00A6_2022, "sub"};
      vecs[2]  = '{4'd3,  5'd8,  5'd9,  5'd7,  16'h5555, 26'h1555555, 1'b1, 32'h0109_382A, "slt"};
      vecs[3]  = '{4'd4,  5'd31, 5'd5,  5'd9,  16'hFFFF, 26'h3FFFFFF, 1'b1, 32'h03E0_0008, "jr"};
      vecs[4]  = '{4'd6,  5'd3,  5'd4,  5'd31, 16'h8000, 26'h3FFFFFF, 1'b1, 32'h2864_8000, "slti"};
      vecs[5]  = '{4'd7,  5'd1,  5'd1,  5'd31, 16'h00FF, 26'h3FFFFFF, 1'b1, 32'h3421_00FF, "ori"};
      vecs[6]  = '{4'd8,  5'd0,  5'd5,  5'd31, 16'h1234, 26'h3FFFFFF, 1'b1, 32'h3C05_1234, "lui"};
      vecs[7]  = '{4'd10, 5'd29, 5'd31, 5'd31, 16'h0008, 26'h3FFFFFF, 1'b1, 32'hAFBF_0008, "sw"};
      vecs[8]  = '{4'd11, 5'd1,  5'd2,  5'd31, 16'hFFFF, 26'h3FFFFFF, 1'b1, 32'h1022_FFFF, "beq"};
      vecs[9]  = '{4'd12, 5'd4,  5'd0,  5'd31, 16'hFFFE, 26'h3FFFFFF, 1'b1, 32'h1480_FFFE, "bne"};
      vecs[10] = '{4'd13, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h0100000, 1'b1, 32'h0810_0000, "j"};
      vecs[11] = '{4'd14, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 1'b1, 32'h0FFF_FFFF, "jal"};
      vecs[12] = '{4'd0,  5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 1'b1, 32'h0000_0000, "nop"};
`ifdef MIPS_ENC_CHECK_EN
      vecs[13] = '{4'd8,  5'd7,  5'd5,  5'd0,  16'h1234, 26'h0000000, 1'b0, 32'h0000_0000, "lui_rs"};
`else
      vecs[13] = '{4'd8,  5'd7,  5'd5,  5'd0,  16'h1234, 26'h0000000, 1'b1, 32'h3C05_1234, "lui_rs"};
`endif

      reset = 1'b1; start = 1'b0; finish = 1'b0;
      set_instr(4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
      in_valid = 1'b0;
      step(); step();
      reset = 1'b0;
      step();
      // reset state
      chk("rst_we", {31'd0, imem_we}, 32'd0);
      chk("rst_addr", {24'd0, imem_addr}, 32'd0);
      chk("rst_wdata", imem_wdata, 32'd0);
      chk("rst_count", {23'd0, count}, 32'd0);
      chk("rst_flags", {28'd0, full, done, err, in_ready}, 32'd0);

      // table of single-instruction loads
      for (int i = 0; i < 14; i++) begin
         do_start();
         chk({vecs[i].name, "_ready"}, {31'd0, in_ready}, 32'd1);
         set_instr(vecs[i].mnem, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm, vecs[i].target);
         step();
         in_valid = 1'b0;
         chk({vecs[i].name, "_we"}, {31'd0, imem_we}, {31'd0, vecs[i].exp_we});
         chk({vecs[i].name, "_count"}, {23'd0, count}, {31'd0, vecs[i].exp_we});
         if (vecs[i].exp_we) begin
            chk({vecs[i].name, "_wdata"}, imem_wdata, vecs[i].exp_word);
            chk({vecs[i].name, "_addr"}, {24'd0, imem_addr}, 32'd0);
         end else begin
            chk({vecs[i].name, "_err"}, {31'd0, err}, 32'd1);
         end
      end

      // back-to-back addi then lw
      do_start();
      set_instr(4'd5, 5'd0, 5'd8, 5'd0, 16'd5, 26'd0);
      step();
      chk("b2b0_we", {31'd0, imem_we}, 32'd1);
      chk("b2b0_addr", {24'd0, imem_addr}, 32'd0);
      chk("b2b0_wdata", imem_wdata, 32'h2008_0005);
      set_instr(4'd9, 5'd29, 5'd2, 5'd0, 16'd4, 26'd0);
      step();
      in_valid = 1'b0;
      chk("b2b1_we", {31'd0, imem_we}, 32'd1);
      chk("b2b1_addr", {24'd0, imem_addr}, 32'd1);
      chk("b2b1_wdata", imem_wdata, 32'h8FA2_0004);
      chk("b2b1_count", {23'd0, count}, 32'd2);
      step();
      chk("b2b_idle_we", {31'd0, imem_we}, 32'd0);

      // DEPTH boundary: five offered, four written
      do_start();
      for (int k = 0; k < 5; k++) begin
         set_instr(4'd5, 5'd0, 5'd1, 5'd0, 16'(k), 26'd0);
         step();
         if (k < 4) begin
            chk("dep_we", {31'd0, imem_we}, 32'd1);
            chk("dep_addr", {24'd0, imem_addr}, k);
            chk("dep_wdata", imem_wdata, 32'h2001_0000 | k);
            chk("dep_count", {23'd0, count}, k + 1);
            chk("dep_full", {31'd0, full}, (k == 3) ? 32'd1 : 32'd0);
            chk("dep_ready", {31'd0, in_ready}, (k == 3) ? 32'd0 : 32'd1);
         end else begin
            chk("dep5_we", {31'd0, imem_we}, 32'd0);
            chk("dep5_count", {23'd0, count}, 32'd4);
         end
      end
      in_valid = 1'b0;
      finish = 1'b1;
      step();
      finish = 1'b0;
      chk("dep_done", {30'd0, done, full}, 32'd3);
      chk("dep_done_ready", {31'd0, in_ready}, 32'd0);
      do_start();
      chk("restart_flags", {29'd0, full, done, in_ready}, 32'd1);
      set_instr(4'd1, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
      step();
      in_valid = 1'b0;
      chk("restart_addr", {24'd0, imem_addr}, 32'd0);
      chk("restart_we", {31'd0, imem_we}, 32'd1);

      // illegal mnemonic followed by a legal one
      do_start();
      set_instr(4'd15, 5'd3, 5'd3, 5'd3, 16'hFFFF, 26'h3FFFFFF);
      step();
      set_instr(4'd1, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
`ifdef MIPS_ENC_CHECK_EN
      chk("ill_we", {31'd0, imem_we}, 32'd0);
      chk("ill_err", {31'd0, err}, 32'd1);
      step();
      in_valid = 1'b0;
      chk("ill_next_addr", {24'd0, imem_addr}, 32'd0);
`else
      chk("ill_we", {31'd0, imem_we}, 32'd1);
      chk("ill_wdata", imem_wdata, 32'd0);
      chk("ill_err", {31'd0, err}, 32'd0);
      step();
      in_valid = 1'b0;
      chk("ill_next_addr", {24'd0, imem_addr}, 32'd1);
`endif
      chk("ill_next_wdata", imem_wdata, 32'h0022_1820);

      // accept together with finish
      do_start();
      set_instr(4'd1, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
      finish = 1'b1;
      step();
      in_valid = 1'b0;
      finish = 1'b0;
      chk("fin_we", {31'd0, imem_we}, 32'd1);
      chk("fin_done", {31'd0, done}, 32'd1);
      chk("fin_ready", {31'd0, in_ready}, 32'd0);
      step();
      chk("fin_after_we", {31'd0, imem_we}, 32'd0);

      // reset right after an accept drops the pending write
      do_start();
      set_instr(4'd1, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
      step();
      in_valid = 1'b0;
      reset = 1'b1;
      #1;
      chk("mid_rst_we", {31'd0, imem_we}, 32'd0);
      chk("mid_rst_addr_data", imem_wdata | {24'd0, imem_addr}, 32'd0);
      chk("mid_rst_count", {23'd0, count}, 32'd0);
      chk("mid_rst_flags", {28'd0, full, done, err, in_ready}, 32'd0);
      step();
      reset = 1'b0;
      step(); step();
      chk("post_rst_ready", {31'd0, in_ready}, 32'd0);
      chk("post_rst_we", {31'd0, imem_we}, 32'd0);
      do_start();
      chk("post_rst_start", {31'd0, in_ready}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/mips_instr_encoder.md
# mips_instr_encoder

Sequential program loader that encodes symbolic MIPS instructions (mnemonic code plus register/immediate fields) into 32-bit machine words and writes them into the single-cycle core's instruction memory. It produces the same opcode/funct encodings that the core's control decoder consumes: nop, add, sub, slt, jr, addi, slti, ori, lui, lw, sw, beq, bne, j and jal. It sits between the testbench or boot host and the instruction memory write port. It accepts one instruction per cycle over a valid/ready handshake.

## Interface
- ADDR_W, 8, instruction-memory word-address width
- BASE_ADDR, 0, first word address written after `start`
- DEPTH, 256, number of words the loader may write (BASE_ADDR+DEPTH ≤ 2^ADDR_W)
- clk  in  1  rising-edge clock; the block's only clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  pulse: begin or restart a program load
- finish  in  1  pulse: end the load
- in_valid  in  1  instruction fields valid
- in_ready  out  1  encoder can accept this cycle
- in_mnem  in  4  0 nop, 1 add, 2 sub, 3 slt, 4 jr, 5 addi, 6 slti, 7 ori, 8 lui, 9 lw, 10 sw, 11 beq, 12 bne, 13 j, 14 jal, 15 illegal
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_imm  in  16  immediate / branch offset
- in_target  in  26  jump target field
- imem_we  out  1  write strobe
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded word
- count  out  ADDR_W+1  words written this load
- full  out  1  DEPTH words written
- done  out  1  load finished
- err  out  1  sticky illegal-instruction flag

## Operation
- FSM states: IDLE, LOAD, FULL, DONE. Reset state is IDLE.
- IDLE→LOAD on `start`. In LOAD, `in_ready`=1.
- LOAD→FULL when the accepted word makes `count`==DEPTH. In FULL, `in_ready`=0 and `full`=1.
- LOAD or FULL → DONE on `finish`. In DONE, `done`=1 and `in_ready`=0.
- `start` in any state sets the state to LOAD, sets the address to BASE_ADDR, and clears `count`, `full`, `done` and `err`. It takes priority over `finish`.
- An instruction is accepted when in_valid & in_ready.
- R-type encoding: op=0, then rs[25:21], rt[20:16], rd[15:11], shamt=0, funct. Funct values: add 0x20, sub 0x22, slt 0x2A, jr 0x08. For jr, rt and rd are forced to 0.
- nop encodes as 32'h0.
- I-type encoding: op[31:26], rs, rt, imm[15:0]. Opcodes: addi 0x08, slti 0x0A, ori 0x0D, lui 0x0F (rs forced to 0), lw 0x23, sw 0x2B, beq 0x04, bne 0x05.
- J-type encoding: op[31:26], target[25:0]. Opcodes: j 0x02, jal 0x03.
- Unused fields are masked to 0. Raw field values never leak into unused bit positions.
- After each write the address increments by 1. The address wraps modulo 2^ADDR_W, but FULL stops acceptance before any wrap can be reached.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N produces `imem_we`=1 with its addr/wdata during cycle N+1.
- Throughput is 1 word per cycle.
- `count` and `full` update in the same cycle as the write.
- `in_ready` is a registered value derived from the state; it is not combinational from `in_valid`.
- Simultaneous accept and `finish`: the word is still written in the next cycle, then the state moves to DONE.
- The accept that reaches DEPTH: it is written; `in_ready` is 0 from the next cycle.
- Reset mid-load: a pending write is dropped.
- Reset values of all outputs: `imem_we`, `imem_addr`, `imem_wdata`, `count`, `full`, `done`, `err` and `in_ready` are all 0.

## Configuration
- Macro: MIPS_ENC_CHECK_EN.
- Defined: `in_mnem`=15, or lui with in_rs≠0, sets `err` (sticky). For that instruction no write occurs and the address does not advance.
- Undefined: the illegal mnemonic encodes as 32'h0 (nop) and is written normally. lui silently masks rs. `err` is tied to 0.

## Structure
- Shared package `mips_pkg` holds:
  - the mnemonic enum;
  - opcode constants: OP_RTYPE, OP_ADDI, OP_SLTI, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL;
  - funct constants: FN_ADD, FN_SUB, FN_SLT, FN_JR.
- The control decoder uses the same constants.
- One combinational sub-module, `mips_instr_pack`, maps mnem and fields to a 32-bit word plus an illegal flag. The top level holds the FSM, the address counter and the output register.

## Test plan
- add rd=3 rs=1 rt=2 after `start` → imem_we at addr 0 with 0x00221820, count=1.
- Back-to-back: addi rt=8 rs=0 imm=5, then lw rt=2 rs=29 imm=4 → 0x20080005 at addr 0 and 0x8FA20004 at addr 1, on consecutive cycles.
- Remaining encodings:
  - j target=0x0100000 → 0x08100000;
  - beq rs=1 rt=2 imm=0xFFFF → 0x1022FFFF;
  - jr rs=31 rt=5 → 0x03E00008.
- DEPTH=4, BASE_ADDR=0, 5 instructions offered → writes to addrs 0..3; full=1 and in_ready=0 after the 4th; the 5th is never written. `start` then restarts at addr 0.
- in_mnem=15 → with MIPS_ENC_CHECK_EN: err=1, no write, next valid word lands at the unchanged address. Without it: 0x00000000 written, err=0.
- Reset asserted the cycle after an accept → no imem_we, all outputs 0, state IDLE. in_ready stays 0 until `start`.
